ands_asr_adder: RTL and testbench
=================================

ANDS_ASR_ADDER -- requirements
Module: ands_asr_adder

Interface
- REQ-001: Clock and reset: one clock; reset is asynchronous and active-high.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  asynchronous active-high reset.
- REQ-004: global_enable  input  1  when 1, the op is executed on the clock edge.
- REQ-005: instruction  input  3  op select: 0 = hold/NOP, 1 = ANDS, 2 = ASR, 3 = ADDS, 4 = ADCS; values 5-7 are illegal.
- REQ-006: num1  input  32  first operand; the value shifted for ASR.
- REQ-007: num2  input  32  second operand; bits [4:0] give the ASR shift amount.
- REQ-008: result  output  32  registered result.
- REQ-009: flags  output  4  registered status flags: bit0 = N, bit1 = Z, bit2 = C, bit3 = V.

Function
- REQ-010: All datapaths (AND, arithmetic shift right, 32-bit adder) SHALL be combinational; result and flags SHALL update only on the rising clk edge, giving 1-cycle latency.
- REQ-011: ANDS: result = num1 & num2; N = result[31]; Z = (result == 0); C = 0; V held.
- REQ-012: ASR with sh = num2[4:0]: result = num1 arithmetically shifted right by sh, with num1[31] replicated into the vacated bits.
- REQ-013: ASR carry: if sh > 0, C = num1[sh-1]; if sh = 0, result = num1 and C is held.
- REQ-014: ASR flags: N = result[31]; Z = (result == 0); V held.
- REQ-015: ADDS: {cout, sum} = num1 + num2 + 0 computed at 33 bits; result = sum; C = cout; N = sum[31]; Z = (sum == 0).
- REQ-016: ADCS: same as ADDS, but carry-in = the registered flags[2] value present before the edge.
- REQ-017: instruction 0: result and flags held.
- REQ-018: instruction 5-7: result is set to 0 and flags are held.
- REQ-019: global_enable = 0: result and flags held regardless of instruction.
- REQ-020: Back-to-back ops SHALL be supported every cycle; an ADCS directly after an ADDS SHALL use the C produced by that ADDS.

Reset
- REQ-021: While rst = 1, result SHALL be 0x0000_0000 and flags SHALL be 4'b0000, taking effect immediately without waiting for clk.
- REQ-022: Reset asserted mid-sequence SHALL discard the pending op; the first op after deassertion SHALL execute on the next enabled rising edge.

Configuration
- REQ-023: Macro ANDS_ASR_ADDER_VFLAG_EN defined: ADDS/ADCS SHALL set V = (num1[31] == num2[31]) && (sum[31] != num1[31]).
- REQ-024: Macro ANDS_ASR_ADDER_VFLAG_EN undefined: V SHALL be constant 0 and no overflow logic SHALL be built; all other behaviour is identical.

Verification
- REQ-025: ANDS, num1 = 0xF0F0_00FF, num2 = 0x0FF0_00F0 -> result 0x00F0_00F0; N=0, Z=0, C=0.
- REQ-026: ASR, num1 = 0x8000_0010, num2 = 5 -> result 0xFC00_0000; N=1, Z=0, C=1. Then ASR with num2 = 0 -> result = num1 and C stays 1.
- REQ-027: ADDS 0xFFFF_FFFF + 0x1 -> result 0, Z=1, C=1, N=0. Then ADCS 2 + 3 -> result 6, C=0.
- REQ-028: ADDS 0x7FFF_FFFF + 0x1 -> result 0x8000_0000, N=1, C=0; V=1 with the macro defined, V=0 without.
- REQ-029: Control: after a valid op, drive global_enable = 0 and change the operands -> outputs unchanged. Apply instruction 6 -> result 0 and flags held. Assert rst between clock edges -> result and flags 0 at once.

Source files
------------

// File: rtl/ands_asr_adder.sv
// ands_asr_adder: registered single-op ALU slice offering ANDS, ASR, ADDS and ADCS
// with NZCV status flags. Operands are evaluated combinationally; result and flags
// update on the rising clk edge (1-cycle latency). No backpressure: an op can be
// issued every cycle, and global_enable = 0 freezes all state.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            asynchronous active-high reset (result = 0, flags = 0)
//   global_enable  1 = execute the selected op on this edge, 0 = hold everything
//   instruction    0 NOP, 1 ANDS, 2 ASR, 3 ADDS, 4 ADCS, 5-7 illegal (result cleared)
//   num1           first operand / value shifted by ASR
//   num2           second operand; [4:0] is the ASR shift amount
//   result         registered 32-bit result
//   flags          registered {V, C, Z, N} (bit0 = N, bit1 = Z, bit2 = C, bit3 = V)
//
// Configuration:
//   ANDS_ASR_ADDER_VFLAG_EN  when defined, ADDS/ADCS compute signed overflow into V.
//                            When undefined, V is tied to 0 and no overflow logic exists.

module ands_asr_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        global_enable,
    input  logic [2:0]  instruction,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    // ------------------------------------------------------------------
    // Op encodings and flag bit positions
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ANDS = 3'd1;
    localparam logic [2:0] OP_ASR  = 3'd2;
    localparam logic [2:0] OP_ADDS = 3'd3;
    localparam logic [2:0] OP_ADCS = 3'd4;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic n_q;
    logic z_q;
    logic c_q;
    logic v_q;

    logic [31:0] result_nxt;
    logic        n_nxt;
    logic        z_nxt;
    logic        c_nxt;
    logic        v_nxt;

    // ------------------------------------------------------------------
    // AND datapath
    // ------------------------------------------------------------------
    logic [31:0] and_res;

    assign and_res = num1 & num2;

    // ------------------------------------------------------------------
    // Arithmetic shift right datapath
    // ------------------------------------------------------------------
    logic [4:0]  sh_amt;
    logic [31:0] asr_res;
    logic        asr_c;

    assign sh_amt  = num2[4:0];
    assign asr_res = $unsigned($signed(num1) >>> sh_amt);

    // Carry is the last bit shifted out; a zero shift moves nothing out,
    // so the previous carry is kept.
    always_comb begin
        asr_c = c_q;
        if (sh_amt != 5'd0) begin
            asr_c = num1[sh_amt - 5'd1];
        end
    end

    // ------------------------------------------------------------------
    // 33-bit adder shared by ADDS and ADCS
    // ------------------------------------------------------------------
    logic        add_cin;
    logic [32:0] add_full;
    logic [31:0] add_sum;
    logic        add_c;

    // ADCS consumes the registered carry, so an ADCS right after an ADDS sees
    // the carry that ADDS just wrote.
    assign add_cin  = (instruction == OP_ADCS) ? c_q : 1'b0;
    assign add_full = {1'b0, num1} + {1'b0, num2} + {32'd0, add_cin};
    assign add_sum  = add_full[31:0];
    assign add_c    = add_full[32];

`ifdef ANDS_ASR_ADDER_VFLAG_EN
    // Signed overflow: both operands share a sign that the sum does not.
    logic add_v;

    assign add_v = (num1[31] == num2[31]) && (add_sum[31] != num1[31]);
`endif

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        result_nxt = result;
        n_nxt      = n_q;
        z_nxt      = z_q;
        c_nxt      = c_q;
        v_nxt      = v_q;

        if (global_enable) begin
            case (instruction)
                OP_NOP: begin
                    // hold everything
                end
                OP_ANDS: begin
                    result_nxt = and_res;
                    n_nxt      = and_res[31];
                    z_nxt      = (and_res == 32'd0);
                    c_nxt      = 1'b0;
                end
                OP_ASR: begin
                    result_nxt = asr_res;
                    n_nxt      = asr_res[31];
                    z_nxt      = (asr_res == 32'd0);
                    c_nxt      = asr_c;
                end
                OP_ADDS, OP_ADCS: begin
                    result_nxt = add_sum;
                    n_nxt      = add_sum[31];
                    z_nxt      = (add_sum == 32'd0);
                    c_nxt      = add_c;
`ifdef ANDS_ASR_ADDER_VFLAG_EN
                    v_nxt      = add_v;
`endif
                end
                default: begin
                    // Illegal op: clear the result, leave flags untouched.
                    result_nxt = 32'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 32'd0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
        end else begin
            result <= result_nxt;
            n_q    <= n_nxt;
            z_q    <= z_nxt;
            c_q    <= c_nxt;
        end
    end

`ifdef ANDS_ASR_ADDER_VFLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_nxt;
        end
    end
`else
    // No overflow tracking in this build: V is a constant zero.
    assign v_q = 1'b0;

    logic unused_v;
    assign unused_v = v_nxt;
`endif

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = n_q;
        flags[FLAG_Z] = z_q;
        flags[FLAG_C] = c_q;
        flags[FLAG_V] = v_q;
    end

endmodule

// File: tb/tb_ands_asr_adder.sv
module tb_ands_asr_adder;

    logic        clk;
    logic        rst;
    logic        global_enable;
    logic [2:0]  instruction;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [31:0] result;
    logic [3:0]  flags;

    ands_asr_adder dut (
        .clk           (clk),
        .rst           (rst),
        .global_enable (global_enable),
        .instruction   (instruction),
        .num1          (num1),
        .num2          (num2),
        .result        (result),
        .flags         (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: what result/flags should be after each edge.
    logic [31:0] m_res;
    logic [3:0]  m_flags;   // {V, C, Z, N}

    task automatic check(input string name, input logic [31:0] ar, input logic [3:0] af,
                         input logic [31:0] er, input logic [3:0] ef);
        vectors++;
        if (ar !== er || af !== ef) begin
            miscompares++;
            $display("FAIL %s: got result=%08h flags=%04b, expected result=%08h flags=%04b",
                     name, ar, af, er, ef);
        end
    endtask

    // Reference behaviour computed from the op definitions with plain arithmetic.
    task automatic model_step(input logic en, input logic [2:0] ins,
                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        n, z, c, v;
        logic [63:0] u;
        longint      s;
        int          sh;
        logic        cin;
        if (!en) return;
        r = m_res;
        n = m_flags[0];
        z = m_flags[1];
        c = m_flags[2];
        v = m_flags[3];
        case (ins)
            3'd0: ;
            3'd1: begin
                r = a & b;
                n = r[31];
                z = (r == 0);
                c = 1'b0;
            end
            3'd2: begin
                sh = int'(b[4:0]);
                if (sh == 0) begin
                    r = a;
                end else begin
                    for (int i = 0; i < 32; i++)
                        r[i] = (i + sh < 32) ? a[i + sh] : a[31];
                    c = a[sh - 1];
                end
                n = r[31];
                z = (r == 0);
            end
            3'd3, 3'd4: begin
                cin = (ins == 3'd4) ? m_flags[2] : 1'b0;
                u = 64'(a) + 64'(b) + 64'(cin);
                r = u[31:0];
                c = u[32];
                n = r[31];
                z = (r == 0);
`ifdef ANDS_ASR_ADDER_VFLAG_EN
                s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
                s = 0;
                v = 1'b0;
`endif
            end
            default: r = 32'd0;
        endcase
        m_res   = r;
        m_flags = {v, c, z, n};
    endtask

    // Drive one op at the falling edge and queue what the next rising edge must produce.
    task automatic do_op(input logic en, input logic [2:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        global_enable = en;
        instruction   = ins;
        num1          = a;
        num2          = b;
        model_step(en, ins, a, b);
        sb.push_back({m_res, m_flags});
    endtask

    // Reset between edges with an op pending; that op must be discarded.
    task automatic mid_reset(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #3;
        global_enable = 1'b1;
        instruction   = 3'd3;
        num1          = a;
        num2          = b;
        rst           = 1'b1;
        #1;
        check("async_rst_immediate", result, flags, 32'd0, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_held_over_edge", result, flags, 32'd0, 4'b0000);
        @(negedge clk);
        rst           = 1'b0;
        global_enable = 1'b0;
        m_res         = 32'd0;
        m_flags       = 4'b0000;
        sb.push_back({m_res, m_flags});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'(  $urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one output per edge; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("scoreboard", result, flags, e.res, e.flg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        global_enable = 1'b0;
        instruction   = 3'd0;
        num1          = 32'd0;
        num2          = 32'd0;
        m_res         = 32'd0;
        m_flags       = 4'b0000;

        #2;
        check("reset_state", result, flags, 32'd0, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back({m_res, m_flags});

        // Directed cases
        do_op(1'b1, 3'd1, 32'hF0F0_00FF, 32'h0FF0_00F0);   // ANDS
        do_op(1'b1, 3'd2, 32'h8000_0010, 32'd5);           // ASR by 5
        do_op(1'b1, 3'd2, 32'h8000_0010, 32'd0);           // ASR by 0 keeps C
        do_op(1'b1, 3'd2, 32'h4000_0001, 32'hFFFF_FFFF);   // ASR by 31
        do_op(1'b1, 3'd3, 32'hFFFF_FFFF, 32'd1);           // ADDS carry out, zero
        do_op(1'b1, 3'd4, 32'd2, 32'd3);                   // ADCS uses that carry
        do_op(1'b1, 3'd4, 32'd2, 32'd3);                   // ADCS with C clear
        do_op(1'b1, 3'd3, 32'h7FFF_FFFF, 32'd1);           // signed overflow
        do_op(1'b1, 3'd3, 32'h8000_0000, 32'h8000_0000);   // negative overflow + carry
        do_op(1'b0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);   // disabled: hold
        do_op(1'b1, 3'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D);   // NOP: hold
        do_op(1'b1, 3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D);   // illegal: result 0, flags kept
        do_op(1'b1, 3'd3, 32'hAAAA_AAAA, 32'h5555_5555);
        mid_reset(32'h1111_1111, 32'h2222_2222);
        do_op(1'b1, 3'd4, 32'h0000_0010, 32'h0000_0001);   // first op after reset

        // Random stream
        for (int i = 0; i < 400; i++) begin
            if (i == 200)
                mid_reset($urandom, $urandom);
            do_op(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  3'($urandom_range(0, 7)), pick(), pick());
        end

        @(negedge clk);
        global_enable = 1'b0;
        @(posedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
